// File: rtl/gpio_pattern_sequencer.sv
// One-hot GPIO pin sequencer: walks a single high pin across the pad bus with a
// programmable per-pin dwell, in forward, reverse, wrapping or ping-pong order.
module gpio_pattern_sequencer #(
   parameter int NUM_PINS       = 34,
   parameter int PRESCALE_W     = 14,
   parameter int TICKS_PER_UNIT = 10000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        start,
   input  logic                        stop,
   input  logic [1:0]                  mode,
   input  logic [PRESCALE_W-1:0]       prescaler,
   output logic [NUM_PINS-1:0]         gpio_out,
   output logic [NUM_PINS-1:0]         gpio_oeb,
   output logic                        done,
   output logic                        busy,
   output logic [$clog2(NUM_PINS)-1:0] cur_pin
);

   localparam int IW = $clog2(NUM_PINS);
   localparam int DW = PRESCALE_W + $clog2(TICKS_PER_UNIT) + 1;
   localparam logic [IW-1:0]       LAST = IW'(NUM_PINS - 1);
   localparam logic [NUM_PINS-1:0] PIN0 = NUM_PINS'(1);

   typedef enum logic {IDLE, RUN} state_t;
   typedef enum logic [1:0] {
      MODE_FWD  = 2'b00,
      MODE_REV  = 2'b01,
      MODE_WRAP = 2'b10,
      MODE_PING = 2'b11
   } mode_t;

   state_t                  state;
   mode_t                   run_mode;
   logic [IW-1:0]           idx;
   logic                    dir_up;
   logic [DW-1:0]           tick_cnt;
   logic [DW-1:0]           dwell_last;
   logic                    start_q;

   logic [PRESCALE_W-1:0]   presc_eff;
   logic [DW-1:0]           dwell_new;
   logic [IW-1:0]           launch_idx;
   logic [IW-1:0]           step_idx;
   logic                    step_dir;
   logic                    step_pass;
   logic                    step_finish;

   assign gpio_oeb = en ? '0 : '1;
   assign cur_pin  = idx;

   // Dwell length and first pin for a run launched this cycle.
   always_comb begin
      presc_eff  = (prescaler == '0) ? PRESCALE_W'(1) : prescaler;
      dwell_new  = DW'(presc_eff) * DW'(TICKS_PER_UNIT);
      launch_idx = (mode == 2'b01) ? LAST : '0;
   end

   // Where the index goes when the current pin's dwell expires.
   always_comb begin
      step_idx    = idx;
      step_dir    = dir_up;
      step_pass   = 1'b0;
      step_finish = 1'b0;
      case (run_mode)
         MODE_FWD: begin
            if (idx == LAST) step_finish = 1'b1;
            else             step_idx    = idx + 1'b1;
         end
         MODE_REV: begin
            if (idx == '0) step_finish = 1'b1;
            else           step_idx    = idx - 1'b1;
         end
         MODE_WRAP: begin
            if (idx == LAST) begin
               step_idx  = '0;
               step_pass = 1'b1;
            end else begin
               step_idx  = idx + 1'b1;
            end
         end
         MODE_PING: begin
            if (dir_up) step_idx = (idx == LAST) ? LAST - 1'b1 : idx + 1'b1;
            else        step_idx = idx - 1'b1;
            // Landing on pin 0 ends a pass; this also covers NUM_PINS == 2.
            if (step_idx == '0) begin
               step_dir  = 1'b1;
               step_pass = 1'b1;
            end else if (dir_up && idx == LAST) begin
               step_dir  = 1'b0;
            end
         end
         default: step_finish = 1'b1;
      endcase
   end

   // Control FSM; every output register is loaded with its next-cycle value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         run_mode   <= MODE_FWD;
         idx        <= '0;
         dir_up     <= 1'b1;
         tick_cnt   <= '0;
         dwell_last <= '0;
         start_q    <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         gpio_out   <= '0;
      end else begin
         start_q <= start;
         done    <= 1'b0;
         if (stop || !en) begin
            state    <= IDLE;
            idx      <= '0;
            tick_cnt <= '0;
            busy     <= 1'b0;
            gpio_out <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !start_q) begin
                     state      <= RUN;
                     run_mode   <= mode_t'(mode);
                     dwell_last <= dwell_new - 1'b1;
                     idx        <= launch_idx;
                     dir_up     <= 1'b1;
                     tick_cnt   <= '0;
                     busy       <= 1'b1;
                     gpio_out   <= PIN0 << launch_idx;
                  end
               end
               RUN: begin
                  if (tick_cnt == dwell_last) begin
                     tick_cnt <= '0;
                     if (step_finish) begin
                        state    <= IDLE;
                        idx      <= '0;
                        busy     <= 1'b0;
                        gpio_out <= '0;
                        done     <= 1'b1;
                     end else begin
                        idx      <= step_idx;
                        dir_up   <= step_dir;
                        gpio_out <= PIN0 << step_idx;
                        done     <= step_pass;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Self-checking bench for gpio_pattern_sequencer: directed scenarios plus
// randomized runs compared against a cycle-arithmetic reference model.
module tb_gpio_pattern_sequencer;

   localparam int N  = 4;
   localparam int T  = 3;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          start;
   logic          stop;
   logic [1:0]    mode;
   logic [PW-1:0] prescaler;
   logic [N-1:0]  gpio_out;
   logic [N-1:0]  gpio_oeb;
   logic          done;
   logic          busy;
   logic [1:0]    cur_pin;

   int checks   = 0;
   int failures = 0;

   gpio_pattern_sequencer #(
      .NUM_PINS(N),
      .PRESCALE_W(PW),
      .TICKS_PER_UNIT(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .start(start),
      .stop(stop),
      .mode(mode),
      .prescaler(prescaler),
      .gpio_out(gpio_out),
      .gpio_oeb(gpio_oeb),
      .done(done),
      .busy(busy),
      .cur_pin(cur_pin)
   );

   always #5 clk = ~clk;

   // Expected pin/busy/done in cycle c after a launch in cycle 0.
   function automatic void model_step(input int m, input int d, input int c,
                                      output int pin, output logic exp_busy,
                                      output logic exp_done);
      int k;
      int per;
      int j;
      k        = (c - 1) / d;
      per      = 2 * (N - 1);
      pin      = -1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      case (m)
         0: begin
            if (k < N) begin pin = k; exp_busy = 1'b1; end
            else exp_done = (c == N * d + 1);
         end
         1: begin
            if (k < N) begin pin = N - 1 - k; exp_busy = 1'b1; end
            else exp_done = (c == N * d + 1);
         end
         2: begin
            pin      = k % N;
            exp_busy = 1'b1;
            exp_done = (c > 1) && ((c - 1) % (N * d) == 0);
         end
         default: begin
            j        = k % per;
            pin      = (j < N) ? j : per - j;
            exp_busy = 1'b1;
            exp_done = (c > 1) && ((c - 1) % (per * d) == 0);
         end
      endcase
   endfunction

   function automatic logic [N-1:0] pin_bits(input int pin);
      logic [N-1:0] one;
      one = N'(1);
      return (pin < 0) ? '0 : (one << pin);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_prep();
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0;
      mode = 2'b00; prescaler = '0;
      repeat (3) tick();
      checks++;
      if (gpio_out !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gpio_out got %b expected 0000", gpio_out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b expected 0", done); end
      checks++;
      if (cur_pin !== 2'd0) begin failures++; $display("[TB] FAIL reset_cur_pin got %0d expected 0", cur_pin); end
      checks++;
      if (gpio_oeb !== 4'b0000) begin failures++; $display("[TB] FAIL reset_oeb_en got %b expected 0000", gpio_oeb); end
      en = 1'b0;
      #1;
      checks++;
      if (gpio_oeb !== 4'b1111) begin failures++; $display("[TB] FAIL reset_oeb_dis got %b expected 1111", gpio_oeb); end
      en  = 1'b1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_sequence_modes();
      int fix_mode[4]  = '{0, 1, 3, 2};
      int fix_presc[4] = '{2, 0, 2, 1};
      int fix_hold[4]  = '{0, 0, 0, 1};
      for (int t = 0; t < 10; t++) begin
         int m, p, hold, d, ncyc, pin;
         logic eb, ed;
         if (t < 4) begin
            m = fix_mode[t]; p = fix_presc[t]; hold = fix_hold[t];
         end else begin
            m = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 1));
         end
         d    = ((p == 0) ? 1 : p) * T;
         ncyc = (m < 2) ? N * d + 4 : 4 * (N - 1) * d + 2;
         idle_prep();
         mode      = 2'(m);
         prescaler = PW'(p);
         start     = 1'b1;
         tick();
         if (hold == 0) start = 1'b0;
         mode      = 2'($urandom);
         prescaler = PW'($urandom);
         for (int c = 1; c <= ncyc; c++) begin
            model_step(m, d, c, pin, eb, ed);
            checks++;
            if (gpio_out !== pin_bits(pin)) begin
               failures++;
               $display("[TB] FAIL seq%0d_gpio_out mode %0d cycle %0d got %b expected %b", t, m, c, gpio_out, pin_bits(pin));
            end
            checks++;
            if (busy !== eb) begin
               failures++;
               $display("[TB] FAIL seq%0d_busy mode %0d cycle %0d got %b expected %b", t, m, c, busy, eb);
            end
            checks++;
            if (done !== ed) begin
               failures++;
               $display("[TB] FAIL seq%0d_done mode %0d cycle %0d got %b expected %b", t, m, c, done, ed);
            end
            if (eb) begin
               checks++;
               if (cur_pin !== 2'(pin)) begin
                  failures++;
                  $display("[TB] FAIL seq%0d_cur_pin mode %0d cycle %0d got %0d expected %0d", t, m, c, cur_pin, pin);
               end
            end
            tick();
         end
         start = 1'b0;
      end
   endtask

   task automatic test_abort_held_start();
      logic relaunched;
      idle_prep();
      mode = 2'b10; prescaler = PW'(1);
      start = 1'b1;
      tick();
      for (int c = 1; c < 10; c++) tick();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre_busy got %b expected 1", busy); end
      stop = 1'b1;
      tick();
      checks++;
      if (gpio_out !== 4'b0000) begin failures++; $display("[TB] FAIL abort_gpio_out got %b expected 0000", gpio_out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got %b expected 0", done); end
      checks++;
      if (cur_pin !== 2'd0) begin failures++; $display("[TB] FAIL abort_cur_pin got %0d expected 0", cur_pin); end
      stop = 1'b0;
      relaunched = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0) relaunched = 1'b1;
      end
      checks++;
      if (relaunched !== 1'b0) begin failures++; $display("[TB] FAIL held_start_relaunch got %b expected 0", relaunched); end
      start = 1'b0;
      tick();
      start = 1'b1; stop = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_beats_start got %b expected 0", busy); end
      stop = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stale_edge_busy got %b expected 0", busy); end
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL new_edge_busy got %b expected 1", busy); end
      checks++;
      if (gpio_out !== 4'b0001) begin failures++; $display("[TB] FAIL new_edge_gpio_out got %b expected 0001", gpio_out); end
      start = 1'b0;
   endtask

   task automatic test_latch_enable();
      int pin;
      logic eb, ed;
      idle_prep();
      mode = 2'b00; prescaler = PW'(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 15; c++) begin
         model_step(0, 6, c, pin, eb, ed);
         checks++;
         if (gpio_out !== pin_bits(pin)) begin
            failures++;
            $display("[TB] FAIL latch_gpio_out cycle %0d got %b expected %b", c, gpio_out, pin_bits(pin));
         end
         if (c == 8) begin
            prescaler = PW'(5);
            mode      = 2'b01;
         end
         tick();
      end
      en = 1'b0;
      #1;
      checks++;
      if (gpio_oeb !== 4'b1111) begin failures++; $display("[TB] FAIL en_low_oeb got %b expected 1111", gpio_oeb); end
      tick();
      checks++;
      if (gpio_out !== 4'b0000) begin failures++; $display("[TB] FAIL en_low_gpio_out got %b expected 0000", gpio_out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL en_low_busy got %b expected 0", busy); end
      start = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL en_low_launch got %b expected 0", busy); end
      en = 1'b1; start = 1'b0;
      tick();
      checks++;
      if (gpio_oeb !== 4'b0000) begin failures++; $display("[TB] FAIL en_high_oeb got %b expected 0000", gpio_oeb); end
   endtask

   task automatic test_reset_mid_run();
      idle_prep();
      mode = 2'b10; prescaler = PW'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (gpio_out !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_gpio_out got %b expected 0000", gpio_out); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done got %b expected 0", done); end
      checks++;
      if (cur_pin !== 2'd0) begin failures++; $display("[TB] FAIL midrst_cur_pin got %0d expected 0", cur_pin); end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after_busy got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      idle_prep();
      mode = 2'b00; prescaler = PW'(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 13; c++) tick();
      checks++;
      if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done got %b expected 1", done); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_idle got %b expected 0", busy); end
      mode  = 2'b01;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_relaunch_busy got %b expected 1", busy); end
      checks++;
      if (gpio_out !== 4'b1000) begin failures++; $display("[TB] FAIL b2b_gpio_out got %b expected 1000", gpio_out); end
      checks++;
      if (cur_pin !== 2'd3) begin failures++; $display("[TB] FAIL b2b_cur_pin got %0d expected 3", cur_pin); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_single got %b expected 0", done); end
      repeat (3) tick();
      checks++;
      if (gpio_out !== 4'b0100) begin failures++; $display("[TB] FAIL b2b_second_pin got %b expected 0100", gpio_out); end
   endtask

   initial begin
      test_reset();
      test_sequence_modes();
      test_abort_held_start();
      test_latch_enable();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
